// File: rtl/sign_extend_pkg.sv
// Shared opcode constants, format codes and immediate field widths for the
// LEGv8 immediate generator.
package sign_extend_pkg;

  localparam int XLEN     = 64;
  localparam int SHAMT_W  = 6;
  localparam int IMM9_W   = 9;
  localparam int IMM12_W  = 12;
  localparam int IMM16_W  = 16;
  localparam int IMM19_W  = 19;
  localparam int IMM26_W  = 26;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_D    = 3'd3,
    FMT_B    = 3'd4,
    FMT_CB   = 3'd5,
    FMT_IM   = 3'd6
  } fmt_e;

  // 11-bit opcodes, in[31:21]
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // 10-bit opcodes, in[31:22]
  localparam logic [9:0] OP_ADDI = 10'b1001000100;
  localparam logic [9:0] OP_SUBI = 10'b1101000100;
  localparam logic [9:0] OP_ANDI = 10'b1001001000;
  localparam logic [9:0] OP_ORRI = 10'b1011001000;

  // 9-bit opcodes, in[31:23]
  localparam logic [8:0] OP_MOVZ = 9'b110100101;
  localparam logic [8:0] OP_MOVK = 9'b111100101;

  // 8-bit opcodes, in[31:24]
  localparam logic [7:0] OP_CBZ   = 8'b10110100;
  localparam logic [7:0] OP_CBNZ  = 8'b10110101;
  localparam logic [7:0] OP_BCOND = 8'b01010100;

  // 6-bit opcodes, in[31:26]
  localparam logic [5:0] OP_B  = 6'b000101;
  localparam logic [5:0] OP_BL = 6'b100101;

endpackage

// File: rtl/sext_decode.sv
// Combinational opcode match and immediate extract/extend; longest opcode
// is tested first so shorter prefixes never shadow a longer encoding.
module sext_decode
  import sign_extend_pkg::*;
(
  input  logic [31:0] instr,
  output logic [63:0] next_out,
  output logic [2:0]  next_fmt
);

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [8:0]  op9;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic        r_hit, d_hit, i_hit, im_hit, cb_hit, b_hit;
  logic [63:0] imm16_zx;

  assign op11 = instr[31:21];
  assign op10 = instr[31:22];
  assign op9  = instr[31:23];
  assign op8  = instr[31:24];
  assign op6  = instr[31:26];

  assign r_hit  = (op11 == OP_ADD) || (op11 == OP_SUB) || (op11 == OP_AND) ||
                  (op11 == OP_ORR) || (op11 == OP_EOR) || (op11 == OP_LSL) ||
                  (op11 == OP_LSR);
  assign d_hit  = (op11 == OP_LDUR) || (op11 == OP_STUR);
  assign i_hit  = (op10 == OP_ADDI) || (op10 == OP_SUBI) ||
                  (op10 == OP_ANDI) || (op10 == OP_ORRI);
  assign im_hit = (op9 == OP_MOVZ) || (op9 == OP_MOVK);
  assign cb_hit = (op8 == OP_CBZ) || (op8 == OP_CBNZ) || (op8 == OP_BCOND);
  assign b_hit  = (op6 == OP_B) || (op6 == OP_BL);

  assign imm16_zx = {{(XLEN-IMM16_W){1'b0}}, instr[20:5]};

  always_comb begin
    next_out = '0;
    next_fmt = FMT_NONE;
    if (r_hit) begin
      next_out = {{(XLEN-SHAMT_W){1'b0}}, instr[15:10]};
      next_fmt = FMT_R;
    end else if (d_hit) begin
      next_out = {{(XLEN-IMM9_W){instr[20]}}, instr[20:12]};
      next_fmt = FMT_D;
    end else if (i_hit) begin
      next_out = {{(XLEN-IMM12_W){1'b0}}, instr[21:10]};
      next_fmt = FMT_I;
    end else if (im_hit) begin
      // hw field selects which 16-bit lane the immediate lands in
      next_out = imm16_zx << {instr[22:21], 4'b0000};
      next_fmt = FMT_IM;
    end else if (cb_hit) begin
      next_out = {{(XLEN-IMM19_W){instr[23]}}, instr[23:5]};
      next_fmt = FMT_CB;
    end else if (b_hit) begin
      next_out = {{(XLEN-IMM26_W){instr[25]}}, instr[25:0]};
      next_fmt = FMT_B;
    end
  end

endmodule

// File: rtl/sign_extend.sv
// LEGv8 immediate generator: decodes the instruction word and registers the
// extended immediate and its format code (one cycle of latency).
module sign_extend
  import sign_extend_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in,
  output logic [63:0] out,
  output logic [2:0]  fmt
);

  logic [63:0] dec_out;
  logic [2:0]  dec_fmt;
  logic [63:0] out_d, out_q;
  logic [2:0]  fmt_d, fmt_q;

  sext_decode u_decode (
    .instr    (in),
    .next_out (dec_out),
    .next_fmt (dec_fmt)
  );

  always_comb begin
    out_d = dec_out;
    fmt_d = dec_fmt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      fmt_q <= FMT_NONE;
    end else begin
      out_q <= out_d;
      fmt_q <= fmt_d;
    end
  end

  assign out = out_q;
  assign fmt = fmt_q;

endmodule

// File: tb/tb_sign_extend.sv
// Scoreboard bench for sign_extend: stimulus pushes hand-computed expectations,
// a monitor pops and compares one cycle after each applied instruction.
module tb_sign_extend;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] tb_in;
  logic [63:0] out;
  logic [2:0]  fmt;

  typedef struct {
    logic [63:0] out;
    logic [2:0]  fmt;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  bit   stim_done    = 1'b0;

  localparam logic [2:0] F_NONE = 3'd0, F_R = 3'd1, F_I = 3'd2, F_D = 3'd3,
                         F_B = 3'd4, F_CB = 3'd5, F_IM = 3'd6;

  sign_extend dut (
    .clk   (clk),
    .reset (reset),
    .in    (tb_in),
    .out   (out),
    .fmt   (fmt)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic rst, input logic [31:0] instr,
                       input logic [63:0] e_out, input logic [2:0] e_fmt,
                       input string name);
    exp_t e;
    @(negedge clk);
    reset = rst;
    tb_in = instr;
    e.out  = e_out;
    e.fmt  = e_fmt;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: an entry queued before this edge is the value captured at it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        #1;
        tests_run++;
        if (out !== e.out) begin
          tests_failed++;
          $display("FAIL %s out: got %h expected %h", e.name, out, e.out);
        end
        tests_run++;
        if (fmt !== e.fmt) begin
          tests_failed++;
          $display("FAIL %s fmt: got %0d expected %0d", e.name, fmt, e.fmt);
        end
        $display("[TB] %-14s in=%h out=%h fmt=%0d", e.name, dut.in, out, fmt);
      end
    end
  end

  initial begin
    reset = 1'b1;
    tb_in = 32'hFFFF_FFFF;
    apply(1'b1, 32'hFFFF_FFFF, 64'h0, F_NONE, "reset0");
    apply(1'b1, 32'hFFFF_FFFF, 64'h0, F_NONE, "reset1");
    apply(1'b0, 32'h0000_0000, 64'h0, F_NONE, "zero");
    apply(1'b0, 32'b000101_00000000001110000000000001, 64'h0000_0000_0000_E001, F_B, "b_pos");
    apply(1'b0, 32'h17FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, F_B, "b_neg");
    apply(1'b0, 32'b100101_10000000000000000000000000, 64'hFFFF_FFFF_FE00_0000, F_B, "bl_min");
    apply(1'b0, 32'b10001010000_00001_111100_00000_00010, 64'h3C, F_R, "and_sh");
    apply(1'b0, 32'b10001011000_00000_111111_00000_00000, 64'h3F, F_R, "add_sh");
    apply(1'b0, 32'b10101010000_00010_111110_00001_00011, 64'h3E, F_R, "orr_sh");
    apply(1'b0, 32'b11010011010_00000_000101_00001_00010, 64'h05, F_R, "lsr_sh");
    apply(1'b0, 32'b10110100_0000000001111000000_00011, 64'h3C0, F_CB, "cbz_pos");
    apply(1'b0, 32'b10110100_1111111111111111111_00011, 64'hFFFF_FFFF_FFFF_FFFF, F_CB, "cbz_neg");
    apply(1'b0, 32'b10110101_1000000000000000000_00001, 64'hFFFF_FFFF_FFFC_0000, F_CB, "cbnz_min");
    apply(1'b0, 32'b01010100_0000000000000000010_00000, 64'h2, F_CB, "bcond");
    apply(1'b0, 32'b11111000000_000111110_00_00000_00100, 64'h3E, F_D, "stur");
    apply(1'b0, 32'b11111000010_000011100_00_00000_01001, 64'h1C, F_D, "ldur");
    apply(1'b0, 32'b11111000010_111111000_00_00000_01001, 64'hFFFF_FFFF_FFFF_FFF8, F_D, "ldur_neg");
    apply(1'b0, 32'b1001000100_111111111111_00001_00010, 64'hFFF, F_I, "addi_max");
    apply(1'b0, 32'b1101000100_100000000000_00000_00000, 64'h800, F_I, "subi_msb");
    apply(1'b0, 32'b111100101_10_0000111111100000_00011, 64'h0000_0FE0_0000_0000, F_IM, "movk_hw2");
    apply(1'b0, 32'b110100101_00_1000000000000001_00000, 64'h8001, F_IM, "movz_hw0");
    apply(1'b0, 32'b110100101_11_1010101111001101_00000, 64'hABCD_0000_0000_0000, F_IM, "movz_hw3");
    apply(1'b0, 32'b11001011001_111110000000000000010, 64'h0, F_NONE, "nomatch");
    apply(1'b0, 32'b100101_10000000000000000000000000, 64'hFFFF_FFFF_FE00_0000, F_B, "pre_rst");
    apply(1'b1, 32'b100101_10000000000000000000000000, 64'h0, F_NONE, "mid_rst");
    apply(1'b0, 32'b10001010000_00001_111100_00000_00010, 64'h3C, F_R, "post_rst");
    @(negedge clk);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!stim_done && budget < 1000) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (!stim_done || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: stim_done=%0d pending=%0d expected done with 0 pending",
               stim_done, sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
